// File: rtl/instrumentation_trip_unit.sv
// Instrumentation trip unit: per-channel setpoint compare, debounce and trip latch.
//
// Each accepted sample (sample_valid_i=1) compares every channel value against its
// setpoint (unsigned high-trip or signed low-trip per LowTripMask). Consecutive tripping
// samples are counted. A channel's debounced trip asserts once DebounceCnt is reached.
// The debounced trip is then qualified by the channel mode and latched until trip_reset_i.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   sample_valid_i  vals/setpoints/mode valid this cycle
//   vals_i          packed channel samples, channel 0 in the MSBs
//   setpoints_i     packed setpoints, same packing as vals_i
//   mode_i          2 bits per channel, channel 0 in the MSBs
//                   (0 bypass, 1 operate, 2 manual trip, 3 reserved -> trip)
//   trip_reset_i    clear latched trips whose qualified condition is false
//   sensor_trip_o   debounced raw trip, channel i at bit NChannels-1-i
//   trip_out_o      latched qualified trip, same bit order
//   trip_valid_o    one-cycle pulse after each accepted sample
module instrumentation_trip_unit #(
  parameter int unsigned          NChannels   = 3,
  parameter int unsigned          W           = 32,
  parameter logic [NChannels-1:0] LowTripMask = NChannels'(3'b100),
  parameter int unsigned          DebounceCnt = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid_i,
  input  logic [NChannels*W-1:0] vals_i,
  input  logic [NChannels*W-1:0] setpoints_i,
  input  logic [2*NChannels-1:0] mode_i,
  input  logic                   trip_reset_i,
  output logic [NChannels-1:0]   sensor_trip_o,
  output logic [NChannels-1:0]   trip_out_o,
  output logic                   trip_valid_o
);

  localparam int unsigned     CntW   = $clog2(DebounceCnt + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DebounceCnt);

  logic [NChannels-1:0] sensor_trip_q, sensor_trip_d;
  logic [NChannels-1:0] trip_out_q, trip_out_d;
  logic                 trip_valid_q;

  for (genvar i = 0; i < NChannels; i++) begin : g_ch
    // Output/packing position of channel i: channel 0 sits at the MSB end.
    localparam int unsigned B = NChannels - 1 - i;

    logic [W-1:0]    v, sp;
    logic [1:0]      md;
    logic            raw;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            st_nxt;
    logic            q;
    logic            to_nxt;

    assign v  = vals_i[W*B +: W];
    assign sp = setpoints_i[W*B +: W];
    assign md = mode_i[2*B +: 2];

    // Strict compares: equality never trips.
    assign raw = LowTripMask[i] ? ($signed(v) < $signed(sp)) : (sp < v);

    always_comb begin
      cnt_d = cnt_q;
      if (sample_valid_i) begin
        if (!raw) begin
          cnt_d = '0;
        end else if (cnt_q != DebMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Without a sample the held debounced state is used for qualification.
    assign st_nxt = sample_valid_i ? (cnt_d == DebMax) : sensor_trip_q[B];

    always_comb begin
      unique case (md)
        2'd0:    q = 1'b0;
        2'd1:    q = st_nxt;
        default: q = 1'b1;   // manual trip and reserved both fail safe
      endcase
    end

    // A trip still present at reset time wins over the reset request.
    always_comb begin
      to_nxt = trip_out_q[B];
      if (sample_valid_i) begin
        to_nxt = trip_reset_i ? q : (trip_out_q[B] | q);
      end else if (trip_reset_i) begin
        to_nxt = trip_out_q[B] & q;
      end
    end

    assign sensor_trip_d[B] = st_nxt;
    assign trip_out_d[B]    = to_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_trip_q <= '0;
      trip_out_q    <= '0;
      trip_valid_q  <= 1'b0;
    end else begin
      sensor_trip_q <= sensor_trip_d;
      trip_out_q    <= trip_out_d;
      trip_valid_q  <= sample_valid_i;
    end
  end

  assign sensor_trip_o = sensor_trip_q;
  assign trip_out_o    = trip_out_q;
  assign trip_valid_o  = trip_valid_q;

endmodule

// File: tb/tb_instrumentation_trip_unit.sv
module tb_instrumentation_trip_unit;

  localparam int unsigned NCh = 3;
  localparam int unsigned W   = 32;

  logic             clk;
  logic             rst_n;
  logic             sample_valid;
  logic [NCh*W-1:0] vals;
  logic [NCh*W-1:0] setpoints;
  logic [2*NCh-1:0] mode;
  logic             trip_reset;
  logic [NCh-1:0]   sensor_trip;
  logic [NCh-1:0]   trip_out;
  logic             trip_valid;

  logic [W-1:0] v0, v1, v2;
  logic [1:0]   m0, m1, m2;

  int unsigned n_pass;
  int unsigned n_total;

  assign vals      = {v0, v1, v2};
  assign setpoints = {32'd100, 32'd100, 32'hFFFF_FFF6};
  assign mode      = {m0, m1, m2};

  instrumentation_trip_unit #(
    .NChannels  (3),
    .W          (32),
    .LowTripMask(3'b100),
    .DebounceCnt(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid_i(sample_valid),
    .vals_i        (vals),
    .setpoints_i   (setpoints),
    .mode_i        (mode),
    .trip_reset_i  (trip_reset),
    .sensor_trip_o (sensor_trip),
    .trip_out_o    (trip_out),
    .trip_valid_o  (trip_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step(input logic valid, input logic trst);
    sample_valid = valid;
    trip_reset   = trst;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    trip_reset   = 1'b0;
  endtask

  task automatic chk3(input string tag, input logic [2:0] st, input logic [2:0] to,
                      input logic tv);
    chk({tag, ".sensor_trip"}, 32'(sensor_trip), 32'(st));
    chk({tag, ".trip_out"},    32'(trip_out),    32'(to));
    chk({tag, ".trip_valid"},  32'(trip_valid),  32'(tv));
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; sample_valid = 1'b0; trip_reset = 1'b0;
    v0 = '0; v1 = '0; v2 = '0;
    m0 = 2'd1; m1 = 2'd1; m2 = 2'd1;
    @(negedge clk);
    @(negedge clk);
    chk3("reset", 3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ch0 high-trip: 3 samples do not trip, the 4th does.
    v0 = 32'd101;
    repeat (3) step(1'b1, 1'b0);
    chk3("ch0_3samp", 3'b000, 3'b000, 1'b1);
    step(1'b1, 1'b0);
    chk3("ch0_4samp", 3'b100, 3'b100, 1'b1);
    step(1'b0, 1'b0);
    chk3("ch0_idle_hold", 3'b100, 3'b100, 1'b0);

    // Value drops, reset with a sample clears the latch.
    v0 = 32'd50;
    step(1'b1, 1'b1);
    chk3("ch0_reset_clear", 3'b000, 3'b000, 1'b1);

    // Re-trip, then reset while still tripping: the trip wins.
    v0 = 32'd101;
    repeat (4) step(1'b1, 1'b0);
    chk("ch0_retrip", 32'(trip_out), 32'(3'b100));
    step(1'b1, 1'b1);
    chk3("ch0_reset_held", 3'b100, 3'b100, 1'b1);

    // Equality does not trip, so reset clears.
    v0 = 32'd100;
    step(1'b1, 1'b1);
    chk3("ch0_equal", 3'b000, 3'b000, 1'b1);

    // Ch2 signed low-trip: -11 < -10.
    v0 = '0;
    v2 = 32'hFFFF_FFF5;
    repeat (3) step(1'b1, 1'b0);
    chk("ch2_3samp", 32'(sensor_trip), 32'(3'b000));
    step(1'b1, 1'b0);
    chk3("ch2_4samp", 3'b001, 3'b001, 1'b1);
    // +5 is above -10 signed (an unsigned compare would trip).
    v2 = 32'd5;
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    chk3("ch2_pos_notrip", 3'b000, 3'b000, 1'b1);
    v2 = '0;

    // Ch1: a non-tripping sample breaks the run.
    v1 = 32'd200;
    repeat (3) step(1'b1, 1'b0);
    v1 = 32'd7;
    step(1'b1, 1'b0);
    v1 = 32'd200;
    repeat (3) step(1'b1, 1'b0);
    chk3("ch1_broken_run", 3'b000, 3'b000, 1'b1);
    // Idle gap does not break the run: count is 3, next valid sample is the 4th.
    repeat (3) step(1'b0, 1'b0);
    chk3("ch1_gap", 3'b000, 3'b000, 1'b0);
    step(1'b1, 1'b0);
    chk3("ch1_after_gap", 3'b010, 3'b010, 1'b1);
    v1 = '0;
    step(1'b1, 1'b1);
    chk3("ch1_clear", 3'b000, 3'b000, 1'b1);

    // Manual trip on ch2 latches after one sample without a sensor trip.
    m2 = 2'd2;
    step(1'b1, 1'b0);
    chk3("ch2_manual", 3'b000, 3'b001, 1'b1);
    // Reset without a sample: still manual, so it holds.
    step(1'b0, 1'b1);
    chk3("ch2_idle_reset_hold", 3'b000, 3'b001, 1'b0);
    // Back to operate: idle reset now clears.
    m2 = 2'd1;
    step(1'b0, 1'b1);
    chk("ch2_idle_reset_clear", 32'(trip_out), 32'(3'b000));
    // Reserved mode trips fail-safe.
    m1 = 2'd3;
    step(1'b1, 1'b0);
    chk("ch1_reserved", 32'(trip_out), 32'(3'b010));
    m1 = 2'd1;
    step(1'b1, 1'b1);
    chk("ch1_reserved_clear", 32'(trip_out), 32'(3'b000));

    // Bypass: debounced trip visible, not latched; operate latches next sample.
    m0 = 2'd0;
    v0 = 32'd101;
    repeat (4) step(1'b1, 1'b0);
    chk3("ch0_bypass", 3'b100, 3'b000, 1'b1);
    m0 = 2'd1;
    step(1'b1, 1'b0);
    chk3("ch0_operate", 3'b100, 3'b100, 1'b1);
    // Bypass again does not clear the latch.
    m0 = 2'd0;
    v0 = '0;
    step(1'b1, 1'b0);
    chk3("ch0_bypass_hold", 3'b000, 3'b100, 1'b1);
    m0 = 2'd1;
    step(1'b1, 1'b1);
    chk("ch0_clear2", 32'(trip_out), 32'(3'b000));

    // Asynchronous reset mid-debounce (count 3), with a latched manual trip on ch2.
    m2 = 2'd2;
    v0 = 32'd101;
    repeat (3) step(1'b1, 1'b0);
    chk3("pre_async", 3'b000, 3'b001, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("async_reset", 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m2 = 2'd1;
    step(1'b1, 1'b0);
    chk("post_reset_1samp", 32'(sensor_trip), 32'(3'b000));
    repeat (2) step(1'b1, 1'b0);
    chk("post_reset_3samp", 32'(sensor_trip), 32'(3'b000));
    step(1'b1, 1'b0);
    chk3("post_reset_4samp", 3'b100, 3'b100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
